// File: rtl/instruction_sequencer.sv
// instruction_sequencer
// Multi-cycle control sequencer for a small two-register datapath. Each
// instruction is fetched from an external, combinational instruction memory,
// decoded into registered ALU/mux controls, held one cycle for the ALU to
// settle, and then written back with a single-cycle load pulse.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   start      begins execution from IDLE (ignored in every other state)
//   im_addr    instruction-memory address (program counter)
//   im_data    instruction word {op[6:0], lit[7:0]}, combinational from im_addr
//   load_a/b   register write enables, asserted only in WRITE
//   sel_a/b    ALU operand-mux selects
//   alu_s      ALU operation
//   lit        literal operand
//   busy       high while an instruction is in flight (and in PAUSE)
//   done       high only in HALTED
//   instr_cnt  retired-instruction count, saturating at 255
//   step_mode, step   (only with SINGLE_STEP_EN) single-step control
//
// Optional feature: define SINGLE_STEP_EN to add step_mode/step and a PAUSE
// state entered after WRITE while step_mode=1; a step pulse resumes at FETCH.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | im_addr=PC, latch im_data into IR
// DECODE | register control fields from IR, or stop on halt bit
// EXEC   | controls held stable while the ALU settles
// WRITE  | load pulse, count the instruction, advance PC
// HALTED | program finished; absorbing until rst
// PAUSE  | (SINGLE_STEP_EN) waiting for a step pulse

module instruction_sequencer #(
    parameter int ADDR_W   = 6,
    parameter int PROG_LEN = 57
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef SINGLE_STEP_EN
    input  logic              step_mode,
    input  logic              step,
`endif
    output logic [ADDR_W-1:0] im_addr,
    input  logic [14:0]       im_data,
    output logic              load_a,
    output logic              load_b,
    output logic [1:0]        sel_a,
    output logic [1:0]        sel_b,
    output logic [2:0]        alu_s,
    output logic [7:0]        lit,
    output logic              busy,
    output logic              done,
    output logic [7:0]        instr_cnt
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] DECODE = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] WRITE  = 3'd4;
    localparam logic [2:0] HALTED = 3'd5;
`ifdef SINGLE_STEP_EN
    localparam logic [2:0] PAUSE  = 3'd6;
`endif

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [14:0]       ir;
    logic [1:0]        dest;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= '0;
            ir        <= '0;
            instr_cnt <= '0;
            alu_s     <= '0;
            sel_a     <= '0;
            sel_b     <= '0;
            lit       <= '0;
            dest      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= FETCH;
                end
                FETCH: begin
                    ir    <= im_data;
                    state <= DECODE;
                end
                DECODE: begin
                    alu_s <= ir[10:8];
                    dest  <= ir[12:11];
                    sel_a <= ir[13] ? 2'b10 : 2'b00;
                    sel_b <= ir[13] ? 2'b01 : 2'b10;
                    lit   <= ir[7:0];
                    // A halt instruction retires nothing and never reaches WRITE.
                    state <= ir[14] ? HALTED : EXEC;
                end
                EXEC: begin
                    state <= WRITE;
                end
                WRITE: begin
                    if (instr_cnt != 8'hFF) instr_cnt <= instr_cnt + 8'd1;
                    // The last instruction stops the program without wrapping PC.
                    if (pc == LAST_PC) begin
                        state <= HALTED;
                    end else begin
                        pc <= pc + ADDR_W'(1);
`ifdef SINGLE_STEP_EN
                        state <= step_mode ? PAUSE : FETCH;
`else
                        state <= FETCH;
`endif
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
`ifdef SINGLE_STEP_EN
                PAUSE: begin
                    if (step) state <= FETCH;
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign im_addr = pc;
    assign load_a  = (state == WRITE) && dest[0];
    assign load_b  = (state == WRITE) && dest[1];
    assign done    = (state == HALTED);
`ifdef SINGLE_STEP_EN
    assign busy    = (state == FETCH) || (state == DECODE) || (state == EXEC) ||
                     (state == WRITE) || (state == PAUSE);
`else
    assign busy    = (state == FETCH) || (state == DECODE) || (state == EXEC) ||
                     (state == WRITE);
`endif

endmodule
